fpu_wb_collector: RTL

Writeback collector at the output end of the FPU pipelines. Accepts tagged results (`flag` = valid, `add` = 5-bit destination register) from two fixed-latency FPU pipes (pipe A: fadd/fsub, pipe B: fmul) and serialises them onto the single float-register-file write port. Results are written one per cycle, in arrival order, with no loss. Upstream issue is throttled via `stall`.

---
 rtl/fpu_wb_collector.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fpu_wb_collector.sv
// Writeback collector: merges tagged results from two FPU pipes into one
// register-file write port through a circular buffer, oldest first, A before B.
module fpu_wb_collector #(
  parameter int DEPTH = 8,
  parameter int LAT   = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        a_flag,
  input  logic [4:0]  a_add,
  input  logic [31:0] a_data,
  input  logic        b_flag,
  input  logic [4:0]  b_add,
  input  logic [31:0] b_data,
  output logic        wb_en,
  output logic [4:0]  wb_add,
  output logic [31:0] wb_data,
  output logic        stall,
  output logic        overflow
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int SW  = CW + 1;
  localparam int THR = DEPTH - 2 * LAT;
  localparam logic [SW-1:0] DEPTH_W = SW'(DEPTH);
  localparam logic [SW-1:0] THR_W   = SW'(THR);

  logic [36:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  logic [36:0]   a_ent_s;
  logic [36:0]   b_ent_s;
  logic          pop_s;
  logic          fifo_pop_s;
  logic [36:0]   pop_ent_s;
  logic [1:0]    cand_cnt_s;
  logic [36:0]   cand0_s;
  logic [36:0]   cand1_s;
  logic [SW-1:0] space_s;
  logic [1:0]    push_cnt_s;
  logic          drop_s;
  logic [SW-1:0] count_next_s;

  assign a_ent_s = {a_add, a_data};
  assign b_ent_s = {b_add, b_data};

  // Select the head of the logical queue and the results left over to push.
  always_comb begin
    pop_s      = 1'b0;
    fifo_pop_s = 1'b0;
    pop_ent_s  = 37'd0;
    cand_cnt_s = 2'd0;
    cand0_s    = 37'd0;
    cand1_s    = 37'd0;
    if (count_r != CW'(1'b0)) begin
      pop_s      = 1'b1;
      fifo_pop_s = 1'b1;
      pop_ent_s  = mem_r[rd_ptr_r];
      if (a_flag && b_flag) begin
        cand0_s    = a_ent_s;
        cand1_s    = b_ent_s;
        cand_cnt_s = 2'd2;
      end else if (a_flag) begin
        cand0_s    = a_ent_s;
        cand_cnt_s = 2'd1;
      end else if (b_flag) begin
        cand0_s    = b_ent_s;
        cand_cnt_s = 2'd1;
      end else begin
        cand_cnt_s = 2'd0;
      end
    end else if (a_flag) begin
      // Empty buffer: A bypasses straight to the write port.
      pop_s     = 1'b1;
      pop_ent_s = a_ent_s;
      if (b_flag) begin
        cand0_s    = b_ent_s;
        cand_cnt_s = 2'd1;
      end else begin
        cand_cnt_s = 2'd0;
      end
    end else if (b_flag) begin
      pop_s     = 1'b1;
      pop_ent_s = b_ent_s;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Admit as many candidates as fit; the youngest (B) is the first to go.
  always_comb begin
    space_s = DEPTH_W - SW'(count_r) + SW'(fifo_pop_s);
    if (space_s >= SW'(cand_cnt_s)) begin
      push_cnt_s = cand_cnt_s;
    end else begin
      push_cnt_s = space_s[1:0];
    end
    drop_s       = (push_cnt_s != cand_cnt_s);
    count_next_s = SW'(count_r) + SW'(push_cnt_s) - SW'(fifo_pop_s);
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_en    <= 1'b0;
      wb_add   <= 5'd0;
      wb_data  <= 32'd0;
      stall    <= 1'b0;
      overflow <= 1'b0;
      count_r  <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      wb_en <= pop_s;
      if (pop_s) begin
        wb_add  <= pop_ent_s[36:32];
        wb_data <= pop_ent_s[31:0];
      end
      count_r  <= count_next_s[CW-1:0];
      rd_ptr_r <= rd_ptr_r + AW'(fifo_pop_s);
      wr_ptr_r <= wr_ptr_r + AW'(push_cnt_s);
      stall    <= (count_next_s >= THR_W);
      overflow <= overflow | drop_s;
    end
  end

  // Buffer storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_cnt_s != 2'd0) begin
      mem_r[wr_ptr_r] <= cand0_s;
    end
    if (push_cnt_s == 2'd2) begin
      mem_r[wr_ptr_r + AW'(1'b1)] <= cand1_s;
    end
  end

endmodule
